ram_burst_reader: RTL and testbench

RAM_BURST_READER -- requirements
Module: ram_burst_reader

---
 rtl/ram_burst_pkg.sv | 10 +
 rtl/ram_burst_reader_fifo.sv | 46 ++++
 rtl/ram_burst_reader.sv | 98 +++++++++
 tb/tb_ram_burst_reader.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/ram_burst_pkg.sv
// Shared definitions for the burst reader: FSM encoding and default RAM latency.
package ram_burst_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam int RD_LATENCY_DEF = 2;
endpackage

// File: rtl/ram_burst_reader_fifo.sv
// Output buffer: small synchronous FIFO with count output.
// An empty FIFO with simultaneous write and read passes the word straight through.
module sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 33
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp, rp;
  logic             bypass, do_wr, do_rd;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign bypass  = empty & wr_en & rd_en;
  assign do_wr   = wr_en & (~full | rd_en) & ~bypass;
  assign do_rd   = rd_en & ~empty;
  assign rd_data = empty ? wr_data : mem[rp];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (do_wr) wp <= wp + 1'b1;
      if (do_rd) rp <= rp + 1'b1;
      count <= count + CW'(do_wr) - CW'(do_rd);
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wp] <= wr_data;
  end
endmodule

// File: rtl/ram_burst_reader.sv
// Streams a burst of words out of a pipelined RAM port; issue is credit-limited
// so every word in flight already owns a FIFO slot.
module ram_burst_reader
  import ram_burst_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int RD_LATENCY = RD_LATENCY_DEF,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [ADDR_WIDTH-1:0] req_len_m1,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  busy
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_e                 state;
  logic [ADDR_WIDTH-1:0]  rem;
  logic                   init_q;
  logic [RD_LATENCY-1:0]  vld_pipe, last_pipe;
  logic [CW-1:0]          fifo_count, inflight;
  logic [CW:0]            outstanding;
  logic                   issue, fifo_rd, fifo_full, fifo_empty;
  logic [DATA_WIDTH:0]    fifo_rdata;

  always_comb begin
    inflight = '0;
    for (int k = 0; k < RD_LATENCY; k++) inflight = inflight + CW'(vld_pipe[k]);
  end

  assign outstanding = {1'b0, fifo_count} + {1'b0, inflight};
  assign issue       = (state == ISSUE) && (outstanding < (CW+1)'(FIFO_DEPTH));
  // init_q keeps req_ready low until the first edge after reset release
  assign req_ready   = init_q && (state == IDLE);
  assign busy        = (state != IDLE);
  assign out_valid   = ~fifo_empty;
  assign fifo_rd     = out_valid & out_ready;
  assign out_data    = out_valid ? fifo_rdata[DATA_WIDTH-1:0] : '0;
  assign out_last    = out_valid & fifo_rdata[DATA_WIDTH];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      ram_addr  <= '0;
      rem       <= '0;
      init_q    <= 1'b0;
      vld_pipe  <= '0;
      last_pipe <= '0;
    end else begin
      init_q       <= 1'b1;
      vld_pipe[0]  <= issue;
      last_pipe[0] <= issue && (rem == '0);
      for (int k = 1; k < RD_LATENCY; k++) begin
        vld_pipe[k]  <= vld_pipe[k-1];
        last_pipe[k] <= last_pipe[k-1];
      end
      case (state)
        IDLE: if (req_valid && req_ready) begin
          ram_addr <= req_addr;
          rem      <= req_len_m1;
          state    <= ISSUE;
        end
        ISSUE: if (issue) begin
          ram_addr <= ram_addr + 1'b1;
          rem      <= rem - 1'b1;
          if (rem == '0) state <= DRAIN;
        end
        DRAIN: if (fifo_rd && fifo_rdata[DATA_WIDTH]) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_WIDTH + 1)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (vld_pipe[RD_LATENCY-1]),
    .wr_data ({last_pipe[RD_LATENCY-1], ram_rdata}),
    .rd_en   (fifo_rd),
    .rd_data (fifo_rdata),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );
endmodule

// File: tb/tb_ram_burst_reader.sv
// Directed bench for ram_burst_reader against a 2-cycle pipelined RAM model.
module tb_ram_burst_reader;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int L  = 2;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          req_valid, req_ready;
  logic [AW-1:0] req_addr, req_len_m1, ram_addr;
  logic [DW-1:0] ram_rdata, out_data;
  logic          out_valid, out_ready, out_last, busy;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [DW-1:0] mem [1024];
  logic [DW-1:0] rp [L];
  logic [DW-1:0] bd [$];
  logic          bl [$];
  int            bc [$];

  ram_burst_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(L), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_len_m1(req_len_m1), .ram_addr(ram_addr),
    .ram_rdata(ram_rdata), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    rp[0] <= mem[ram_addr];
    for (int k = 1; k < L; k++) rp[k] <= rp[k-1];
  end
  assign ram_rdata = rp[L-1];

  // beats are recorded half a cycle before the edge that completes their handshake
  always @(negedge clk) begin
    if (reset_n && out_valid && out_ready) begin
      bd.push_back(out_data);
      bl.push_back(out_last);
      bc.push_back(cyc);
    end
  end

  function automatic logic [DW-1:0] exp_word(input logic [AW-1:0] a);
    return (a == 10'h010) ? 32'hDEADBEEF : {22'h0, a};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_beats();
    bd.delete(); bl.delete(); bc.delete();
  endtask

  task automatic start_req(input logic [AW-1:0] a, input logic [AW-1:0] len);
    req_valid = 1'b1; req_addr = a; req_len_m1 = len;
    checks++;
    if (req_ready !== 1'b1) begin failures++; $display("FAIL start_req_ready got=%b want=1", req_ready); end
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string nm);
    for (int n = 0; n < budget && busy; n++) tick();
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL %s_timeout busy=%b want=0", nm, busy); end
  endtask

  task automatic check_burst(input string nm, input logic [AW-1:0] a, input int n);
    checks++;
    if (bd.size() != n) begin failures++; $display("FAIL %s_count got=%0d want=%0d", nm, bd.size(), n); end
    for (int i = 0; i < bd.size() && i < n; i++) begin
      logic [AW-1:0] ai;
      ai = a + AW'(i);
      checks++;
      if (bd[i] !== exp_word(ai) || bl[i] !== (i == n-1)) begin
        failures++;
        $display("FAIL %s_beat%0d got=%h/%b want=%h/%b", nm, i, bd[i], bl[i], exp_word(ai), (i == n-1));
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_len_m1 = '0; out_ready = 1'b1;
    #2;
    checks++;
    if ({out_valid, out_last, busy, req_ready} !== 4'b0000 || out_data !== '0 || ram_addr !== '0) begin
      failures++;
      $display("FAIL reset_outputs got v=%b l=%b b=%b r=%b d=%h a=%h want all 0",
               out_valid, out_last, busy, req_ready, out_data, ram_addr);
    end
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    checks++;
    if (req_ready !== 1'b0) begin failures++; $display("FAIL reset_ready_pre_edge got=%b want=0", req_ready); end
    tick();
    checks++;
    if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_ready_post_edge got=%b want=1", req_ready); end
  endtask

  task automatic test_single();
    clear_beats();
    start_req(10'h010, 10'h000);
    checks++;
    if (ram_addr !== 10'h010 || busy !== 1'b1 || out_valid !== 1'b0) begin
      failures++; $display("FAIL single_accept got a=%h b=%b v=%b want 010/1/0", ram_addr, busy, out_valid);
    end
    tick(); tick();
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL single_early_valid got=%b want=0", out_valid); end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'hDEADBEEF || out_last !== 1'b1) begin
      failures++; $display("FAIL single_beat got v=%b d=%h l=%b want 1/deadbeef/1", out_valid, out_data, out_last);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || req_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++; $display("FAIL single_after got b=%b r=%b v=%b want 0/1/0", busy, req_ready, out_valid);
    end
  endtask

  task automatic test_wrap();
    clear_beats();
    start_req(10'h3FC, 10'd7);
    wait_idle(50, "wrap");
    check_burst("wrap", 10'h3FC, 8);
    for (int i = 1; i < bc.size(); i++) begin
      checks++;
      if (bc[i] - bc[0] != i) begin failures++; $display("FAIL wrap_gap%0d got=%0d want=%0d", i, bc[i]-bc[0], i); end
    end
  endtask

  task automatic test_backpressure();
    logic [AW-1:0] held;
    clear_beats();
    start_req(10'h100, 10'd15);
    for (int n = 0; n < 50 && bd.size() < 2; n++) tick();
    out_ready = 1'b0;
    for (int n = 0; n < 10; n++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== 32'h102 || (ram_addr - 10'h100) > 10'd6) begin
        failures++;
        $display("FAIL bp_stall%0d got v=%b d=%h a=%h want 1/102/<=106", n, out_valid, out_data, ram_addr);
      end
      tick();
    end
    held = ram_addr;
    checks++;
    if (held !== 10'h106) begin failures++; $display("FAIL bp_addr_hold got=%h want=106", held); end
    out_ready = 1'b1;
    wait_idle(80, "bp");
    check_burst("bp", 10'h100, 16);
  endtask

  task automatic test_reset_mid();
    int stale;
    clear_beats();
    start_req(10'h200, 10'd15);
    for (int n = 0; n < 50 && bd.size() < 4; n++) tick();
    checks++;
    if (out_valid !== 1'b1) begin failures++; $display("FAIL rmid_fifth_valid got=%b want=1", out_valid); end
    reset_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || out_data !== '0 || req_ready !== 1'b0) begin
      failures++; $display("FAIL rmid_async got v=%b b=%b d=%h r=%b want 0/0/0/0", out_valid, busy, out_data, req_ready);
    end
    tick(); tick();
    reset_n = 1'b1;
    tick();
    checks++;
    if (req_ready !== 1'b1) begin failures++; $display("FAIL rmid_ready got=%b want=1", req_ready); end
    stale = 0;
    for (int n = 0; n < 10; n++) begin
      if (out_valid) stale++;
      tick();
    end
    checks++;
    if (stale != 0) begin failures++; $display("FAIL rmid_stale got=%0d want=0", stale); end
  endtask

  task automatic test_back_to_back();
    int last_cyc, acc_cyc, n;
    clear_beats();
    last_cyc = -1; acc_cyc = -1;
    req_valid = 1'b1; req_addr = 10'h020; req_len_m1 = 10'd1;
    tick();
    req_addr = 10'h030; req_len_m1 = 10'd0;
    for (n = 0; n < 40 && acc_cyc < 0; n++) begin
      if (out_valid && out_ready && out_last) last_cyc = n;
      if (req_ready) acc_cyc = n;
      tick();
    end
    req_valid = 1'b0;
    checks++;
    if (last_cyc < 0 || acc_cyc != last_cyc + 1) begin
      failures++; $display("FAIL b2b_accept got=%0d want=%0d", acc_cyc, last_cyc + 1);
    end
    wait_idle(40, "b2b");
    checks++;
    if (bd.size() != 3 || bd[0] !== 32'h20 || bd[1] !== 32'h21 || bd[2] !== 32'h30 || bl[1] !== 1'b1 || bl[2] !== 1'b1) begin
      failures++; $display("FAIL b2b_beats got n=%0d want 20,21(last),30(last)", bd.size());
    end
  endtask

  task automatic test_full_sweep();
    int nlast;
    clear_beats();
    start_req(10'h000, 10'h3FF);
    wait_idle(1500, "sweep");
    check_burst("sweep", 10'h000, 1024);
    nlast = 0;
    foreach (bl[i]) if (bl[i]) nlast++;
    checks++;
    if (nlast != 1) begin failures++; $display("FAIL sweep_lasts got=%0d want=1", nlast); end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = i;
    mem[16] = 32'hDEADBEEF;
    test_reset();
    test_single();
    test_wrap();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_full_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
